// File: rtl/ipsec_mem_pkg.sv
// Shared defaults and FSM encoding for the on-chip-RAM to Avalon-ST stream reader.
package ipsec_mem_pkg;
    localparam int AW         = 11;
    localparam int DW         = 32;
    localparam int FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } fsm_t;
endpackage

// File: rtl/ipsec_sync_fifo.sv
// Small show-ahead FIFO: head word is visible on head_data whenever count is non-zero.
module ipsec_sync_fifo #(
    parameter int DW    = 32,
    parameter int DEPTH = 4,
    parameter int PW    = $clog2(DEPTH),
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] head_data,
    output logic [CW-1:0] count
);
    logic [DW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: nothing is read until count says it was written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_n) begin
            assert (!(push && !pop && (count_q == CW'(DEPTH))));
            assert (!(pop && (count_q == '0)));
        end
    end

    assign head_data = mem_q[rd_ptr_q];
    assign count     = count_q;
endmodule

// File: rtl/ipsec_mem_stream_reader.sv
// Avalon-MM read master streaming a block of RAM words out as one Avalon-ST packet.
module ipsec_mem_stream_reader #(
    parameter int AW         = ipsec_mem_pkg::AW,
    parameter int DW         = ipsec_mem_pkg::DW,
    parameter int FIFO_DEPTH = ipsec_mem_pkg::FIFO_DEPTH
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic [AW:0]   len_words,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] mem_address,
    output logic          mem_chipselect,
    output logic          mem_write,
    output logic [3:0]    mem_byteenable,
    output logic          mem_clken,
    input  logic [DW-1:0] mem_readdata,
    output logic [DW-1:0] st_data,
    output logic          st_valid,
    input  logic          st_ready,
    output logic          st_sop,
    output logic          st_eop
);
    import ipsec_mem_pkg::*;

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    fsm_t          state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW:0]   issue_left_q, issue_left_d;
    logic [AW:0]   out_left_q, out_left_d;
    logic          sop_pending_q, sop_pending_d;
    logic          done_q, done_d;
    logic          inflight_q;

    logic [CW-1:0] fifo_count;
    logic [DW-1:0] fifo_head;
    logic [CW:0]   credit_used;
    logic          pop;
    logic          issue;
    logic          start_ok;

    assign pop      = st_valid & st_ready;
    assign start_ok = start && (len_words != '0);

    // Words buffered plus the one still in the RAM pipe, less the one leaving now.
    assign credit_used = {1'b0, fifo_count} + (CW+1)'(inflight_q) - (CW+1)'(pop);
    assign issue       = (state_q == ISSUE) && (credit_used < (CW+1)'(FIFO_DEPTH));

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        issue_left_d  = issue_left_q;
        out_left_d    = out_left_q;
        sop_pending_d = sop_pending_q;
        done_d        = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_ok) begin
                    state_d       = ISSUE;
                    addr_d        = base_addr;
                    issue_left_d  = len_words;
                    out_left_d    = len_words;
                    sop_pending_d = 1'b1;
                end
            end
            ISSUE: begin
                if (issue) begin
                    addr_d       = addr_q + AW'(1);
                    issue_left_d = issue_left_q - (AW+1)'(1);
                    if (issue_left_q == (AW+1)'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            default: begin
            end
        endcase

        // The last beat always leaves at least two cycles after the last issue.
        if (pop) begin
            out_left_d    = out_left_q - (AW+1)'(1);
            sop_pending_d = 1'b0;
            if (out_left_q == (AW+1)'(1)) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            issue_left_q  <= '0;
            out_left_q    <= '0;
            sop_pending_q <= 1'b0;
            done_q        <= 1'b0;
            inflight_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            issue_left_q  <= issue_left_d;
            out_left_q    <= out_left_d;
            sop_pending_q <= sop_pending_d;
            done_q        <= done_d;
            inflight_q    <= issue;
        end
    end

    ipsec_sync_fifo #(
        .DW    (DW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (inflight_q),
        .push_data (mem_readdata),
        .pop       (pop),
        .head_data (fifo_head),
        .count     (fifo_count)
    );

    assign busy           = (state_q != IDLE);
    assign done           = done_q;
    assign mem_address    = addr_q;
    assign mem_chipselect = issue;
    assign mem_write      = 1'b0;
    assign mem_byteenable = 4'hF;
    assign mem_clken      = 1'b1;
    assign st_valid       = (fifo_count != '0);
    assign st_data        = fifo_head;
    assign st_sop         = st_valid & sop_pending_q;
    assign st_eop         = st_valid & (out_left_q == (AW+1)'(1));
endmodule
